// File: rtl/ext_trig_pkg.sv
// Shared definitions for the external trigger scheduler.
// State indices, default widths and the one-hot state encoding.
// Optional feature macro used by the scheduler: EXT_TRIG_DELTA_T_EN.
package ext_trig_pkg;

    localparam int unsigned IDLE       = 0;
    localparam int unsigned ISSUE      = 1;
    localparam int unsigned HOLDOFF    = 2;
    localparam int unsigned REARM      = 3;

    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned HOLD_W_DEF = 16;
    localparam int unsigned DELTA_T_W  = 32;

    // One-hot encoding built from the state indices so the bit positions
    // and the index constants can never drift apart.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001 << IDLE,
        ST_ISSUE   = 4'b0001 << ISSUE,
        ST_HOLDOFF = 4'b0001 << HOLDOFF,
        ST_REARM   = 4'b0001 << REARM
    } state_e;

endpackage

// File: rtl/trig_holdoff_timer.sv
// Loadable down-counter used for the post-handshake deadtime.
// expire is high during the cycle in which the count equals one.
module trig_holdoff_timer
    import ext_trig_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              ttc_clk,
    input  logic              reset40,
    input  logic              load,
    input  logic [HOLD_W-1:0] value,
    output logic              expire
);

    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

    logic [HOLD_W-1:0] cnt_r;
    logic [HOLD_W-1:0] cnt_s;
    logic              expire_r;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_s = cnt_r;
        if (load) begin
            cnt_s = value;
        end else if (cnt_r != HOLD_ZERO) begin
            cnt_s = cnt_r - HOLD_ONE;
        end else begin
            cnt_s = HOLD_ZERO;
        end
    end

    // Count register and registered expire flag (tracks count == 1).
    always_ff @(posedge ttc_clk) begin
        if (reset40) begin
            cnt_r    <= HOLD_ZERO;
            expire_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            expire_r <= (cnt_s == HOLD_ONE);
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/ext_trigger_sched.sv
// External trigger scheduler: throttle veto, holdoff deadtime, valid/ready
// handoff, trigger numbering and accepted/vetoed statistics (ttc_clk domain).
// Optional macro EXT_TRIG_DELTA_T_EN adds ext_trig_delta_t, the tick count
// between successive accepted triggers.
module ext_trigger_sched
    import ext_trig_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              ttc_clk,
    input  logic              reset40,
    input  logic              rst_trigger_timestamp,
    input  logic              enable,
    input  logic [HOLD_W-1:0] holdoff_cycles,
    input  logic              ext_trigger,
    input  logic              throttle,
    output logic              trig_valid,
    input  logic              trig_ready,
    output logic [CNT_W-1:0]  trig_num,
    output logic [CNT_W-1:0]  accepted_count,
    output logic [CNT_W-1:0]  vetoed_count,
    output logic              busy
`ifdef EXT_TRIG_DELTA_T_EN
    ,
    output logic [DELTA_T_W-1:0] ext_trig_delta_t
`endif
);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

    state_e            state_r;
    state_e            state_s;
    logic              busy_r;
    logic              trig_valid_r;
    logic              trig_valid_s;
    logic [CNT_W-1:0]  trig_num_r;
    logic [CNT_W-1:0]  trig_num_s;
    logic [CNT_W-1:0]  accepted_count_r;
    logic [CNT_W-1:0]  accepted_count_s;
    logic [CNT_W-1:0]  vetoed_count_r;
    logic [CNT_W-1:0]  vetoed_count_s;
    logic              ext_trigger_d_r;
    logic              accept_s;
    logic              handshake_s;
    logic              hold_load_s;
    logic              hold_expire_s;
    logic              veto_s;

    trig_holdoff_timer #(
        .HOLD_W (HOLD_W)
    ) u_holdoff (
        .ttc_clk (ttc_clk),
        .reset40 (reset40),
        .load    (hold_load_s),
        .value   (holdoff_cycles),
        .expire  (hold_expire_s)
    );

    // Next-state logic and per-cycle accept/handshake/timer-load strobes.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        hold_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ext_trigger && enable) begin
                    if (throttle) begin
                        state_s = ST_REARM;
                    end else begin
                        state_s  = ST_ISSUE;
                        accept_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (trig_valid_r && trig_ready) begin
                    handshake_s = 1'b1;
                    if (holdoff_cycles == HOLD_ZERO) begin
                        state_s = ST_REARM;
                    end else begin
                        state_s     = ST_HOLDOFF;
                        hold_load_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_HOLDOFF: begin
                if (hold_expire_s) begin
                    state_s = ST_REARM;
                end else begin
                    state_s = ST_HOLDOFF;
                end
            end
            ST_REARM: begin
                if (!ext_trigger) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REARM;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // A rising edge with enable set that does not start an issue is a veto.
    assign veto_s = ext_trigger && !ext_trigger_d_r && enable && !accept_s;

    // Valid flag and counter updates; the counter-reset pulse restarts the
    // counters while still counting an event on the same cycle.
    always_comb begin
        trig_valid_s     = trig_valid_r;
        trig_num_s       = trig_num_r;
        accepted_count_s = accepted_count_r;
        vetoed_count_s   = vetoed_count_r;
        if (accept_s) begin
            trig_valid_s = 1'b1;
        end else if (handshake_s) begin
            trig_valid_s = 1'b0;
        end else begin
            trig_valid_s = trig_valid_r;
        end
        if (rst_trigger_timestamp) begin
            accepted_count_s = accept_s ? CNT_ONE : CNT_ZERO;
            trig_num_s       = accept_s ? CNT_ONE : CNT_ZERO;
            vetoed_count_s   = veto_s   ? CNT_ONE : CNT_ZERO;
        end else begin
            if (accept_s) begin
                accepted_count_s = accepted_count_r + CNT_ONE;
                trig_num_s       = accepted_count_r + CNT_ONE;
            end else begin
                accepted_count_s = accepted_count_r;
                trig_num_s       = trig_num_r;
            end
            if (veto_s) begin
                vetoed_count_s = vetoed_count_r + CNT_ONE;
            end else begin
                vetoed_count_s = vetoed_count_r;
            end
        end
    end

    // State, outputs, counters and the trigger edge register.
    always_ff @(posedge ttc_clk) begin
        if (reset40) begin
            state_r          <= ST_IDLE;
            busy_r           <= 1'b0;
            trig_valid_r     <= 1'b0;
            trig_num_r       <= CNT_ZERO;
            accepted_count_r <= CNT_ZERO;
            vetoed_count_r   <= CNT_ZERO;
            ext_trigger_d_r  <= 1'b0;
        end else begin
            state_r          <= state_s;
            busy_r           <= ~state_s[IDLE];
            trig_valid_r     <= trig_valid_s;
            trig_num_r       <= trig_num_s;
            accepted_count_r <= accepted_count_s;
            vetoed_count_r   <= vetoed_count_s;
            ext_trigger_d_r  <= ext_trigger;
        end
    end

    assign trig_valid     = trig_valid_r;
    assign trig_num       = trig_num_r;
    assign accepted_count = accepted_count_r;
    assign vetoed_count   = vetoed_count_r;
    assign busy           = busy_r;

`ifdef EXT_TRIG_DELTA_T_EN
    localparam logic [DELTA_T_W-1:0] TICK_ZERO = {DELTA_T_W{1'b0}};
    localparam logic [DELTA_T_W-1:0] TICK_ONE  = {{(DELTA_T_W-1){1'b0}}, 1'b1};
    localparam logic [DELTA_T_W-1:0] TICK_MAX  = {DELTA_T_W{1'b1}};

    logic [DELTA_T_W-1:0] tick_r;
    logic [DELTA_T_W-1:0] delta_t_r;

    // Saturating tick counter, captured and restarted on every acceptance.
    always_ff @(posedge ttc_clk) begin
        if (reset40 || rst_trigger_timestamp) begin
            tick_r    <= TICK_ZERO;
            delta_t_r <= TICK_ZERO;
        end else if (accept_s) begin
            tick_r    <= TICK_ZERO;
            delta_t_r <= tick_r;
        end else if (tick_r != TICK_MAX) begin
            tick_r    <= tick_r + TICK_ONE;
        end
    end

    assign ext_trig_delta_t = delta_t_r;
`endif

endmodule

// File: tb/tb_ext_trigger_sched.sv
// Self-checking bench for ext_trigger_sched: a vector table plus hand-written
// sequences, with expected outputs queued at drive time and popped after the edge.
module tb_ext_trigger_sched;

    logic        ttc_clk = 1'b0;
    logic        reset40 = 1'b1;
    logic        rst_trigger_timestamp = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] holdoff_cycles = 16'd0;
    logic        ext_trigger = 1'b0;
    logic        throttle = 1'b0;
    logic        trig_valid;
    logic        trig_ready = 1'b0;
    logic [31:0] trig_num;
    logic [31:0] accepted_count;
    logic [31:0] vetoed_count;
    logic        busy;
`ifdef EXT_TRIG_DELTA_T_EN
    logic [31:0] ext_trig_delta_t;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ttc_clk = ~ttc_clk;

    ext_trigger_sched #(.CNT_W(32), .HOLD_W(16)) dut (
        .ttc_clk               (ttc_clk),
        .reset40               (reset40),
        .rst_trigger_timestamp (rst_trigger_timestamp),
        .enable                (enable),
        .holdoff_cycles        (holdoff_cycles),
        .ext_trigger           (ext_trigger),
        .throttle              (throttle),
        .trig_valid            (trig_valid),
        .trig_ready            (trig_ready),
        .trig_num              (trig_num),
        .accepted_count        (accepted_count),
        .vetoed_count          (vetoed_count),
        .busy                  (busy)
`ifdef EXT_TRIG_DELTA_T_EN
        ,
        .ext_trig_delta_t      (ext_trig_delta_t)
`endif
    );

    typedef struct {
        logic        valid;
        logic [31:0] num;
        logic [31:0] acc;
        logic [31:0] veto;
        logic        busy;
    } exp_t;

    typedef struct {
        logic        rst40;
        logic        rst_ts;
        logic        en;
        logic        ext;
        logic        thr;
        logic        rdy;
        logic [15:0] hold;
        exp_t        e;
    } row_t;

    exp_t sb_q[$];
    row_t vec[$];

    function automatic row_t mk(input logic rst40, input logic rst_ts, input logic en,
                                input logic ext, input logic thr, input logic rdy,
                                input logic [15:0] hold, input logic v,
                                input logic [31:0] num, input logic [31:0] acc,
                                input logic [31:0] veto, input logic b);
        row_t r;
        r.rst40 = rst40; r.rst_ts = rst_ts; r.en = en; r.ext = ext;
        r.thr = thr; r.rdy = rdy; r.hold = hold;
        r.e.valid = v; r.e.num = num; r.e.acc = acc; r.e.veto = veto; r.e.busy = b;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, clock, then compare.
    task automatic step(input string tag, input row_t r);
        exp_t e;
        reset40 = r.rst40; rst_trigger_timestamp = r.rst_ts; enable = r.en;
        ext_trigger = r.ext; throttle = r.thr; trig_ready = r.rdy;
        holdoff_cycles = r.hold;
        sb_q.push_back(r.e);
        @(posedge ttc_clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, " valid"}, {31'd0, trig_valid}, {31'd0, e.valid});
        chk({tag, " num"},   trig_num,            e.num);
        chk({tag, " acc"},   accepted_count,      e.acc);
        chk({tag, " veto"},  vetoed_count,        e.veto);
        chk({tag, " busy"},  {31'd0, busy},       {31'd0, e.busy});
    endtask

    initial begin
        // Columns: rst40 rst_ts en ext thr rdy hold | valid num acc veto busy
        // Basic accept, holdoff 4, 3-cycle pulse
        vec.push_back(mk(0,0,1,1,0,1,16'd4, 1,32'd1,32'd1,32'd0,1));
        vec.push_back(mk(0,0,1,1,0,1,16'd4, 0,32'd1,32'd1,32'd0,1));
        vec.push_back(mk(0,0,1,1,0,1,16'd4, 0,32'd1,32'd1,32'd0,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd4, 0,32'd1,32'd1,32'd0,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd4, 0,32'd1,32'd1,32'd0,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd4, 0,32'd1,32'd1,32'd0,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd4, 0,32'd1,32'd1,32'd0,0));
        // Throttle veto, counter reset, accept, holdoff 0
        vec.push_back(mk(0,0,1,1,1,1,16'd4, 0,32'd1,32'd1,32'd1,1));
        vec.push_back(mk(0,0,1,1,1,1,16'd4, 0,32'd1,32'd1,32'd1,1));
        vec.push_back(mk(0,0,1,0,1,1,16'd4, 0,32'd1,32'd1,32'd1,0));
        vec.push_back(mk(0,1,1,0,0,1,16'd4, 0,32'd0,32'd0,32'd0,0));
        vec.push_back(mk(0,0,1,1,0,0,16'd4, 1,32'd1,32'd1,32'd0,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd0, 0,32'd1,32'd1,32'd0,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd0, 0,32'd1,32'd1,32'd0,0));
        // Backpressure: ready low 10 cycles, second edge vetoed
        vec.push_back(mk(0,0,1,1,0,0,16'd0, 1,32'd2,32'd2,32'd0,1));
        vec.push_back(mk(0,0,1,0,0,0,16'd0, 1,32'd2,32'd2,32'd0,1));
        vec.push_back(mk(0,0,1,1,0,0,16'd0, 1,32'd2,32'd2,32'd1,1));
        vec.push_back(mk(0,0,0,1,1,0,16'd0, 1,32'd2,32'd2,32'd1,1));
        for (int i = 0; i < 6; i++)
            vec.push_back(mk(0,0,1,0,0,0,16'd0, 1,32'd2,32'd2,32'd1,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd0, 0,32'd2,32'd2,32'd1,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd0, 0,32'd2,32'd2,32'd1,0));
        vec.push_back(mk(0,0,1,0,0,1,16'd0, 0,32'd2,32'd2,32'd1,0));
        // enable low: no accept, no veto
        vec.push_back(mk(0,0,0,1,0,1,16'd0, 0,32'd2,32'd2,32'd1,0));
        vec.push_back(mk(0,0,0,0,0,1,16'd0, 0,32'd2,32'd2,32'd1,0));
        // Counter reset coincident with a veto
        vec.push_back(mk(0,1,1,1,1,1,16'd0, 0,32'd0,32'd0,32'd1,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd0, 0,32'd0,32'd0,32'd1,0));
        // Holdoff 1: single holdoff cycle
        vec.push_back(mk(0,0,1,1,0,0,16'd1, 1,32'd1,32'd1,32'd1,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd1, 0,32'd1,32'd1,32'd1,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd1, 0,32'd1,32'd1,32'd1,1));
        vec.push_back(mk(0,0,1,0,0,1,16'd1, 0,32'd1,32'd1,32'd1,0));

        // Reset state
        reset40 = 1'b1;
        repeat (3) @(posedge ttc_clk);
        #1;
        chk("reset valid", {31'd0, trig_valid}, 32'd0);
        chk("reset num",   trig_num,            32'd0);
        chk("reset acc",   accepted_count,      32'd0);
        chk("reset veto",  vetoed_count,        32'd0);
        chk("reset busy",  {31'd0, busy},       32'd0);

        for (int i = 0; i < vec.size(); i++)
            step($sformatf("row%0d", i), vec[i]);

        // Holdoff 0xFFFF: edge during last holdoff cycle vetoed, next accepted
        step("hmax acc", mk(0,0,1,1,0,0,16'hFFFF, 1,32'd2,32'd2,32'd1,1));
        step("hmax hs",  mk(0,0,1,0,0,1,16'hFFFF, 0,32'd2,32'd2,32'd1,1));
        for (int i = 0; i < 65533; i++)
            step("hmax hold", mk(0,0,1,0,0,1,16'hFFFF, 0,32'd2,32'd2,32'd1,1));
        step("hmax veto",  mk(0,0,1,1,0,1,16'hFFFF, 0,32'd2,32'd2,32'd2,1));
        step("hmax rearm", mk(0,0,1,0,0,1,16'hFFFF, 0,32'd2,32'd2,32'd2,1));
        step("hmax idle",  mk(0,0,1,0,0,1,16'hFFFF, 0,32'd2,32'd2,32'd2,0));
        step("hmax next",  mk(0,0,1,1,0,0,16'd0,    1,32'd3,32'd3,32'd2,1));
        step("hmax hs2",   mk(0,0,1,0,0,1,16'd0,    0,32'd3,32'd3,32'd2,1));
        step("hmax idle2", mk(0,0,1,0,0,1,16'd0,    0,32'd3,32'd3,32'd2,0));

        // Wrap: preload accepted_count to all ones
        force dut.accepted_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.accepted_count_r;
        step("wrap acc",  mk(0,0,1,1,0,0,16'd0, 1,32'd0,32'd0,32'd2,1));
        step("wrap hs",   mk(0,0,1,0,0,1,16'd0, 0,32'd0,32'd0,32'd2,1));
        step("wrap idle", mk(0,0,1,0,0,1,16'd0, 0,32'd0,32'd0,32'd2,0));

        // Counter reset coincident with acceptance
        step("pre acc",  mk(0,0,1,1,0,1,16'd0, 1,32'd1,32'd1,32'd2,1));
        step("pre hs",   mk(0,0,1,0,0,1,16'd0, 0,32'd1,32'd1,32'd2,1));
        step("pre idle", mk(0,0,1,0,0,1,16'd0, 0,32'd1,32'd1,32'd2,0));
        step("rts acc",  mk(0,1,1,1,0,0,16'd0, 1,32'd1,32'd1,32'd0,1));
        step("rts hold", mk(0,0,1,0,0,0,16'd0, 1,32'd1,32'd1,32'd0,1));

        // reset40 while a trigger is pending
        step("rst mid",   mk(1,0,1,0,0,0,16'd0, 0,32'd0,32'd0,32'd0,0));
        step("rst after", mk(0,0,1,0,0,1,16'd0, 0,32'd0,32'd0,32'd0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
